// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // RV32I funct3 width/sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Timeout counter width; covers MAX_WAIT up to 65535
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: store replication/strobes, load extract and
// extension, and the illegal-funct3 / misalignment check.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic        write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] load_data_o,
  output logic        err_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half-word out of the read word
  always_comb begin
    byte_s = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Decode width/sign, build lanes and flag illegal or misaligned accesses
  always_comb begin
    mem_wdata_o = 32'd0;
    mem_wstrb_o = 4'b0000;
    load_data_o = 32'd0;
    err_o       = 1'b0;
    case (funct3_i)
      F3_B: begin
        mem_wdata_o = {4{wdata_i[7:0]}};
        mem_wstrb_o = 4'b0001 << addr_lo_i;
        load_data_o = {{24{byte_s[7]}}, byte_s};
      end
      F3_H: begin
        err_o       = addr_lo_i[0];
        mem_wdata_o = {2{wdata_i[15:0]}};
        mem_wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        load_data_o = {{16{half_s[15]}}, half_s};
      end
      F3_W: begin
        err_o       = (addr_lo_i != 2'd0);
        mem_wdata_o = wdata_i;
        mem_wstrb_o = 4'b1111;
        load_data_o = rdata_i;
      end
      F3_BU: begin
        err_o       = write_i;
        load_data_o = {24'd0, byte_s};
      end
      F3_HU: begin
        err_o       = write_i | addr_lo_i[0];
        load_data_o = {16'd0, half_s};
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
    // Loads never drive write lanes
    if (!write_i) begin
      mem_wdata_o = 32'd0;
      mem_wstrb_o = 4'b0000;
    end else begin
      load_data_o = 32'd0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one transaction at a time over a
// valid/ready memory bus, with a response timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 255,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata
);

  // Timeout fires on the MAX_WAIT-th cycle spent in REQ/WAIT
  localparam logic [CNT_W-1:0] CNT_LAST = 16'(MAX_WAIT - 32'd1);

  lsu_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  in_idle_s, in_req_s, timeout_s;
  logic                  sel_write_s;
  logic [2:0]            sel_funct3_s;
  logic [1:0]            sel_addr_lo_s;
  logic [31:0]           sel_wdata_s;
  logic [31:0]           lane_wdata_s, load_data_s;
  logic [3:0]            lane_wstrb_s;
  logic                  access_err_s;

  assign in_idle_s = (state_q == IDLE);
  assign in_req_s  = (state_q == REQ);
  assign timeout_s = (cnt_q == CNT_LAST);

  // In IDLE the checker looks at the incoming request; afterwards at the latch
  assign sel_write_s   = in_idle_s ? req_write     : write_q;
  assign sel_funct3_s  = in_idle_s ? req_funct3    : funct3_q;
  assign sel_addr_lo_s = in_idle_s ? req_addr[1:0] : addr_q[1:0];
  assign sel_wdata_s   = in_idle_s ? req_wdata     : wdata_q;

  lsu_data_align u_align (
    .write_i     (sel_write_s),
    .funct3_i    (sel_funct3_s),
    .addr_lo_i   (sel_addr_lo_s),
    .wdata_i     (sel_wdata_s),
    .rdata_i     (mem_resp_rdata),
    .mem_wdata_o (lane_wdata_s),
    .mem_wstrb_o (lane_wstrb_s),
    .load_data_o (load_data_s),
    .err_o       (access_err_s)
  );

  assign req_ready     = in_idle_s && !reset;
  assign busy          = !in_idle_s;
  assign mem_req_valid = in_req_s;
  assign mem_addr      = in_req_s ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : {ADDR_WIDTH{1'b0}};
  assign mem_we        = in_req_s & write_q;
  assign mem_wdata     = in_req_s ? lane_wdata_s : 32'd0;
  assign mem_wstrb     = in_req_s ? lane_wstrb_s : 4'b0000;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

  // Next-state, latch, timeout and response computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = {CNT_W{1'b0}};
          if (access_err_s) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout_s) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout_s) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else if (mem_resp_valid) begin
          state_d      = RESP;
          resp_rdata_d = write_q ? 32'd0 : load_data_s;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    resp_valid_d = (state_d == RESP);
  end

  // State, latched request, counter and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] mem_b [0:63];

  load_store_unit #(.MAX_WAIT(MW), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom_range(0, 255));
    mem_b[16] = 8'hF3; mem_b[17] = 8'hF2; mem_b[18] = 8'h81; mem_b[19] = 8'h80;
  endtask

  // One transaction: s = cycles mem_req_ready is held low, d = WAIT cycle of the response
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int s, input int d, input string tag);
    int size, off, base, resp_cyc;
    logic legal, to, exp_err, exp_mrv;
    logic [31:0] word, v, exp_rd, exp_wd;
    logic [3:0] exp_st;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((a % size) != 0) legal = 1'b0;
    off  = int'(a % 4);
    base = int'(a[5:2]) * 4;
    word = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
    v = word >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    if (size == 1) begin
      exp_wd = {24'd0, wd[7:0]} * 32'h01010101; exp_st = 4'(1 << off);
    end else if (size == 2) begin
      exp_wd = {16'd0, wd[15:0]} * 32'h00010001; exp_st = 4'(3 << off);
    end else begin
      exp_wd = wd; exp_st = 4'hF;
    end
    to       = legal && (s + 1 + d >= MW);
    exp_err  = !legal || to;
    exp_rd   = (exp_err || w) ? 32'd0 : v;
    resp_cyc = !legal ? 1 : (to ? MW + 1 : s + d + 2);

    @(negedge clk);
    chk({tag, " ready"}, req_ready, 1);
    chk({tag, " idle busy"}, busy, 0);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int c = 1; c <= resp_cyc; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
      chk({tag, " busy"}, busy, 1);
      chk({tag, " resp_valid"}, resp_valid, (c == resp_cyc));
      exp_mrv = legal && (c <= s + 1) && (c <= MW);
      chk({tag, " mem_req_valid"}, mem_req_valid, exp_mrv);
      if (exp_mrv) begin
        chk({tag, " mem_addr"}, mem_addr, a & ~32'd3);
        chk({tag, " mem_we"}, mem_we, w);
        chk({tag, " mem_wstrb"}, mem_wstrb, w ? exp_st : 4'b0000);
        if (w) chk({tag, " mem_wdata"}, mem_wdata, exp_wd);
        mem_req_ready = (c == s + 1);
      end
      if (legal && c == s + 1 + d) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = w ? $urandom : word;
      end
      if (c == resp_cyc) begin
        chk({tag, " resp_err"}, resp_err, exp_err);
        chk({tag, " resp_rdata"}, resp_rdata, exp_rd);
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk({tag, " resp_valid end"}, resp_valid, 0);
    chk({tag, " busy end"}, busy, 0);
    if (w && !exp_err)
      for (int k = 0; k < 4; k++)
        if (exp_st[k]) mem_b[base+k] = exp_wd[8*k +: 8];
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    init_mem();
    repeat (3) @(negedge clk);
    chk("rst req_ready", req_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    reset = 1'b0;

    // Directed loads from word 0x8081F2F3 at 0x10
    txn(1'b0, 3'd0, 32'h13, 32'd0, 0, 1, "LB 13");
    txn(1'b0, 3'd4, 32'h12, 32'd0, 0, 1, "LBU 12");
    txn(1'b0, 3'd1, 32'h10, 32'd0, 0, 1, "LH 10");
    txn(1'b0, 3'd5, 32'h12, 32'd0, 0, 1, "LHU 12");
    // Stores
    txn(1'b1, 3'd0, 32'h11, 32'h000000AB, 0, 1, "SB 11");
    txn(1'b1, 3'd1, 32'h12, 32'h00001234, 0, 1, "SH 12");
    // Error paths
    txn(1'b0, 3'd2, 32'h12, 32'd0, 0, 1, "LW mis");
    txn(1'b1, 3'd1, 32'h13, 32'h5555, 0, 1, "SH mis");
    txn(1'b0, 3'd3, 32'h10, 32'd0, 0, 1, "LD f3");
    // Timeout with ready held low, then a late response
    txn(1'b0, 3'd2, 32'h10, 32'd0, 40, 1, "TO");
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF;
    @(negedge clk); mem_resp_valid = 1'b0;
    chk("late resp_valid", resp_valid, 0);
    chk("late busy", busy, 0);
    // Stalled request
    init_mem();
    txn(1'b0, 3'd2, 32'h10, 32'd0, 5, 1, "stall LW");
    // Reset during WAIT
    @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk); req_valid = 1'b0;
    chk("rw mem_req_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0;
    chk("rw busy wait", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw busy", busy, 0);
    chk("rw mem_req_valid", mem_req_valid, 0);
    chk("rw resp_valid", resp_valid, 0);
    chk("rw req_ready", req_ready, 0);
    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h8081F2F3;
    @(negedge clk); mem_resp_valid = 1'b0;
    chk("stray resp_valid", resp_valid, 0);
    chk("stray busy", busy, 0);
    txn(1'b0, 3'd2, 32'h10, 32'd0, 0, 1, "post rst LW");
    // Random traffic
    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom_range(0, 4), $urandom_range(1, 5), "rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
